adc_spi_responder: RTL and testbench

- SPI slave that models an 8-channel, 12-bit serial ADC, i.e. the converter end of the ADC link that the NIOS system drives (sclk, cs_n, din out of the master; dout back into it).
- Used in simulation and for on-board loopback. It serves parallel sample words from ch_data as 16-bit serial frames.
- Frame format: 4 leading zeros, then 12 data bits MSB first. Channel address comes from the din control bits of the previous frame.
- Sits between the NIOS ADC master pins and a test-signal source, e.g. a tone generator feeding the frequency separators.

---
 rtl/adc_spi_pkg.sv | 8 +
 rtl/sync_edge_detect.sv | 28 ++
 rtl/adc_spi_responder.sv | 121 ++++++++++++
 tb/tb_adc_spi_responder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared frame constants and state type for the ADC SPI responder
package adc_spi_pkg;
    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;
    localparam int ADDR_MSB   = 5;
    localparam int ADDR_LSB   = 3;
    typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer with rise/fall pulses on the synchronized level
module sync_edge_detect #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;
    // shift the pin through the chain and keep one more copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{INIT}};
            prev  <= INIT;
        end else begin
            chain <= (chain << 1) | STAGES'(d);
            prev  <= chain[STAGES-1];
        end
    end
    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI slave modelling an 8-channel 12-bit serial ADC
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int DATA_WIDTH   = 12,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                               clk_clk,
    input  logic                               reset_reset,
    input  logic                               sclk,
    input  logic                               cs_n,
    input  logic                               din,
    output logic                               dout,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
    output logic                               frame_done,
    output logic [2:0]                         frame_channel,
    output logic [2:0]                         next_channel
);
    logic                  sclk_rise, sclk_fall, cs_rise, cs_fall, din_s;
    logic [1:0]            unused_levels, unused_din_edges;
    logic [DATA_WIDTH-1:0] words [8];
    logic [15:0]           load_word, shreg, shreg_nxt;
    logic [7:0]            ctrl, ctrl_nxt;
    logic [4:0]            bit_cnt, bit_cnt_nxt;
    logic [2:0]            cur_ch, cur_ch_nxt, frame_channel_nxt, next_channel_nxt;
    logic                  dout_nxt, frame_done_nxt, last;
    state_t                state, state_nxt;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sclk (
        .clk(clk_clk), .rst(reset_reset), .d(sclk),
        .level(unused_levels[0]), .rise(sclk_rise), .fall(sclk_fall));
    sync_edge_detect #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
        .clk(clk_clk), .rst(reset_reset), .d(cs_n),
        .level(unused_levels[1]), .rise(cs_rise), .fall(cs_fall));
    sync_edge_detect #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_din (
        .clk(clk_clk), .rst(reset_reset), .d(din),
        .level(din_s), .rise(unused_din_edges[0]), .fall(unused_din_edges[1]));

    // unpopulated channel addresses read back as zero
    for (genvar g = 0; g < 8; g++) begin : g_words
        if (g < NUM_CHANNELS) begin : g_live
            assign words[g] = ch_data[g*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_zero
            assign words[g] = '0;
        end
    end

    assign load_word = {{LEAD_ZEROS{1'b0}}, words[next_channel]};
    assign last      = bit_cnt == 5'(FRAME_BITS);

    // state and datapath registers
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state         <= IDLE;
            shreg         <= '0;
            ctrl          <= '0;
            bit_cnt       <= '0;
            cur_ch        <= '0;
            dout          <= 1'b0;
            frame_done    <= 1'b0;
            frame_channel <= '0;
            next_channel  <= '0;
        end else begin
            state         <= state_nxt;
            shreg         <= shreg_nxt;
            ctrl          <= ctrl_nxt;
            bit_cnt       <= bit_cnt_nxt;
            cur_ch        <= cur_ch_nxt;
            dout          <= dout_nxt;
            frame_done    <= frame_done_nxt;
            frame_channel <= frame_channel_nxt;
            next_channel  <= next_channel_nxt;
        end
    end

    // frame sequencing; a cs_n rise takes priority over any coincident sclk edge
    always_comb begin
        state_nxt         = state;
        shreg_nxt         = shreg;
        ctrl_nxt          = ctrl;
        bit_cnt_nxt       = bit_cnt;
        cur_ch_nxt        = cur_ch;
        dout_nxt          = dout;
        frame_done_nxt    = 1'b0;
        frame_channel_nxt = frame_channel;
        next_channel_nxt  = next_channel;
        if (state == IDLE) begin
            dout_nxt = 1'b0;
            if (cs_fall) begin
                shreg_nxt   = load_word;
                ctrl_nxt    = '0;
                bit_cnt_nxt = '0;
                cur_ch_nxt  = next_channel;
                state_nxt   = SHIFT;
            end
        end else if (cs_rise) begin
            state_nxt = IDLE;
            dout_nxt  = 1'b0;
        end else if (sclk_rise && !last) begin
            bit_cnt_nxt = bit_cnt + 5'd1;
            // only the control byte is kept, so ADD2..ADD0 stay at ctrl[5:3]
            if (bit_cnt < 5'd8)
                ctrl_nxt = {ctrl[6:0], din_s};
            if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                frame_done_nxt    = 1'b1;
                frame_channel_nxt = cur_ch;
                next_channel_nxt  = ctrl[ADDR_MSB:ADDR_LSB];
            end
        end else if (sclk_fall && last) begin
            shreg_nxt   = load_word;
            ctrl_nxt    = '0;
            bit_cnt_nxt = '0;
            cur_ch_nxt  = next_channel;
            dout_nxt    = 1'b0;
        end else if (sclk_fall && bit_cnt != 5'd0) begin
            shreg_nxt = shreg << 1;
            dout_nxt  = shreg[14];
        end
    end
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed frames against 8- and 4-channel responders
module tb_adc_spi_responder;
    logic        clk_clk = 1'b0, reset_reset = 1'b1, sclk = 1'b1, cs_n = 1'b1, din = 1'b0;
    logic [95:0] ch_data = '0;
    logic        dout, frame_done, dout4, frame_done4;
    logic [2:0]  frame_channel, next_channel, frame_channel4, next_channel4;
    logic [15:0] w, w4;
    int          compared = 0, mismatched = 0, fd_cnt = 0, fd4_cnt = 0, f0;
    time         t_prev = 0, t_last = 0;

    always #10 clk_clk = ~clk_clk;

    adc_spi_responder dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .sclk(sclk), .cs_n(cs_n), .din(din),
        .dout(dout), .ch_data(ch_data), .frame_done(frame_done),
        .frame_channel(frame_channel), .next_channel(next_channel));

    adc_spi_responder #(.NUM_CHANNELS(4)) dut4 (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .sclk(sclk), .cs_n(cs_n), .din(din),
        .dout(dout4), .ch_data(ch_data[47:0]), .frame_done(frame_done4),
        .frame_channel(frame_channel4), .next_channel(next_channel4));

    // count frame_done pulses and time the last two
    always @(posedge clk_clk) begin
        if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            t_prev <= t_last;
            t_last <= $time;
        end
        if (frame_done4)
            fd4_cnt <= fd4_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [11:0] v);
        ch_data[k*12 +: 12] = v;
    endtask

    task automatic run_bits(input logic [15:0] bits, input int n, output logic [15:0] o, output logic [15:0] o4);
        o  = '0;
        o4 = '0;
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            din  = bits[15-i];
            #250;
            sclk = 1'b1;
            o    = {o[14:0], dout};
            o4   = {o4[14:0], dout4};
            #250;
        end
    endtask

    task automatic frame(input logic [15:0] bits, output logic [15:0] o, output logic [15:0] o4);
        cs_n = 1'b0;
        #300;
        run_bits(bits, 16, o, o4);
        #300;
        cs_n = 1'b1;
        #500;
    endtask

    initial begin
        set_ch(0, 12'hABC);
        set_ch(2, 12'h7FF);
        set_ch(4, 12'h040);
        set_ch(5, 12'h123);
        set_ch(6, 12'h666);
        #53;
        check("rst_dout", dout, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_channel", frame_channel, 0);
        check("rst_next_channel", next_channel, 0);
        reset_reset = 1'b0;
        #200;

        f0 = fd_cnt;
        frame(16'h0000, w, w4);
        check("t1_word", w, 16'h0ABC);
        check("t1_done_count", fd_cnt - f0, 1);
        check("t1_frame_channel", frame_channel, 0);
        check("t1_next_channel", next_channel, 0);

        frame(16'h2800, w, w4);
        check("t2a_word", w, 16'h0ABC);
        check("t2a_next_channel", next_channel, 5);
        frame(16'h0000, w, w4);
        check("t2b_word", w, 16'h0123);
        check("t2b_frame_channel", frame_channel, 5);
        check("t2b_next_channel", next_channel, 0);

        f0 = fd_cnt;
        cs_n = 1'b0;
        #300;
        run_bits(16'h1000, 16, w, w4);
        check("t3a_word", w, 16'h0ABC);
        run_bits(16'h0000, 16, w, w4);
        check("t3b_word", w, 16'h07FF);
        #300;
        cs_n = 1'b1;
        #500;
        check("t3_done_count", fd_cnt - f0, 2);
        check("t3_done_spacing", 32'(t_last - t_prev), 32'd8000);
        check("t3_frame_channel", frame_channel, 2);

        f0 = fd_cnt;
        cs_n = 1'b0;
        #300;
        run_bits(16'h1800, 8, w, w4);
        sclk = 1'b0;
        #250;
        check("t4_pre_abort_dout", dout, 1);
        cs_n = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1;
        check("t4_abort_dout", dout, 0);
        sclk = 1'b1;
        #500;
        check("t4_done_count", fd_cnt - f0, 0);
        check("t4_next_channel", next_channel, 0);
        frame(16'h0000, w, w4);
        check("t4_after_word", w, 16'h0ABC);
        check("t4_after_frame_channel", frame_channel, 0);

        frame(16'h2000, w, w4);
        check("t5_setup_next_channel", next_channel, 4);
        cs_n = 1'b0;
        #300;
        run_bits(16'h2000, 10, w, w4);
        check("t5_pre_reset_dout", dout, 1);
        reset_reset = 1'b1;
        #1;
        check("t5_reset_dout", dout, 0);
        check("t5_reset_next_channel", next_channel, 0);
        cs_n = 1'b1;
        #40;
        reset_reset = 1'b0;
        #500;
        f0 = fd_cnt;
        frame(16'h0000, w, w4);
        check("t5_after_word", w, 16'h0ABC);
        check("t5_after_done_count", fd_cnt - f0, 1);

        f0 = fd4_cnt;
        frame(16'h3000, w, w4);
        check("t6_next_channel4", next_channel4, 6);
        frame(16'h0000, w, w4);
        check("t6_word4", w4, 16'h0000);
        check("t6_word8", w, 16'h0666);
        check("t6_frame_channel4", frame_channel4, 6);
        check("t6_done_count4", fd4_cnt - f0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
